int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Parametrised interrupt controller; successor to the CPU's single `inter` line.
- Collects NCH interrupt sources and applies per-channel edge/level mode, masking and fixed or rotating priority.
- Drives one `irq` request to the CPU and hands the serviced channel id over on an ack/EOI handshake.
- Sits between the I/O port logic and the cpu core, clocked by the core's `clk`.

Parameters:
- NCH, 4, number of interrupt channels (1..16).
- ID_W, 2, width of the channel id; must satisfy 2**ID_W >= NCH.
- EDGE_MASK, {NCH{1'b1}}, per-channel mode: bit=1 rising-edge latched, bit=0 level.
- ROTATE, 0, priority mode: 0 = fixed (channel 0 highest), 1 = rotating.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- src  in  NCH  interrupt sources, already synchronous to clk.
- mask_we  in  1  write strobe for the enable mask.
- mask_wd  in  NCH  new enable mask value (1 = enabled).
- int_ack  in  1  CPU acknowledge pulse, one cycle.
- int_eoi  in  1  CPU end-of-interrupt pulse, one cycle.
- irq  out  1  interrupt request to the CPU.
- int_id  out  ID_W  id of the channel granted at ack; held until the next grant.
- in_service  out  1  high while a granted interrupt awaits EOI.
- pending  out  NCH  current pending vector.
- mask  out  NCH  current enable mask.

Behaviour:
- Reset (reset=0, asynchronous), all registered:
  - irq=0, int_id=0, in_service=0, pending=0, mask=all ones.
  - Edge-detect history=0, priority pointer=0, state=IDLE.
- Edge channels:
  - pending[i] sets at the clock edge where src[i]=1 and prev[i]=0; prev is updated every cycle.
  - pending[i] clears only on grant of channel i.
  - If a new edge and the clear coincide on the same channel, set wins.
- Level channels:
  - pending[i] is a registered copy of src[i]; grant does not clear it.
- Masking:
  - Mask only gates requests; pending still latches while masked.
  - A mask write takes effect at the next edge.
  - If mask_we and an arbitration decision coincide, the decision uses the old mask.
- eligible = pending & mask.
- FSM IDLE:
  - If eligible != 0, go to REQ; irq=1 from the next cycle.
  - Latency: src rises before edge k → pending=1 after edge k → irq=1 after edge k+1.
- FSM REQ (irq=1):
  - If int_ack=1: arbitrate on eligible at this edge, not at request time.
    - int_id ← winner; clear pending[winner] if it is an edge channel.
    - in_service ← 1, irq ← 0, go to SERV.
    - If ROTATE=1, pointer ← (winner+1) mod NCH.
  - Else, if eligible==0 (masked away, or a level source dropped), irq ← 0 and go to IDLE.
- FSM SERV (non-nested):
  - irq stays 0 regardless of eligible.
  - If int_eoi=1, in_service ← 0 and go to IDLE; re-request follows one cycle later if eligible.
- Stray handshakes:
  - int_ack outside REQ is ignored.
  - int_eoi outside SERV is ignored.
  - int_ack and int_eoi together are resolved by the current state alone.
- Priority:
  - Fixed: lowest index among eligible wins.
  - Rotating: first eligible index searching upward from the pointer, wrapping NCH-1 → 0.
- int_id holds its value across IDLE/REQ and changes only on a grant.
- Reset mid-operation (any state): immediate return to reset values; no pending is preserved.

Test Plan:
- Reset, then 1-cycle pulse on src[2] (edge mode, mask all ones):
  - Required: pending=4'b0100 one edge later, irq=1 the following cycle.
  - ack → int_id=2, pending=0, in_service=1, irq=0.
  - eoi → in_service=0, irq stays 0.
- src=4'b1010 rising together, ROTATE=0:
  - First ack → int_id=1; after eoi, irq re-asserts; second ack → int_id=3.
- ROTATE=1, src[0] and src[1] re-pulsed after every grant:
  - Successive grants must be 0, 1, 0, 1 (pointer wraps past 3 to 0).
- Masking:
  - Write mask=4'b1110, pulse src[0] → pending[0]=1 and irq stays 0.
  - Write mask=4'b1111 → irq=1 within 2 cycles; ack → int_id=0.
- Level channel (EDGE_MASK=4'b1110), hold src[0]=1:
  - ack → int_id=0 and pending[0] remains 1.
  - After eoi, irq re-asserts.
  - Drop src[0] while in REQ → irq falls, FSM returns to IDLE.
- Stray handshakes and reset:
  - ack in IDLE and eoi in REQ → no state change.
  - Assert reset=0 mid-SERV → irq=0, in_service=0, pending=0, mask=4'b1111 immediately, before any clock edge.

Source files
------------

// File: rtl/int_ctrl.sv
// int_ctrl: parametrised interrupt controller.
//   Collects NCH sources and applies per-channel edge or level capture, an
//   enable mask, and fixed or rotating priority. It raises one irq to the CPU
//   and reports the granted channel on an ack/EOI handshake (non-nested).
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   src[NCH]          interrupt sources, already synchronous to clk
//   mask_we/mask_wd   enable-mask write strobe and data (1 = enabled)
//   int_ack, int_eoi  CPU acknowledge / end-of-interrupt pulses
//   irq               request to the CPU
//   int_id            channel granted at the last ack, held until the next grant
//   in_service        high while a granted interrupt awaits EOI
//   pending, mask     current pending vector and enable mask

// Per-channel capture: edge channels latch a rising edge until cleared by a
// grant (a new edge in the same cycle as the clear wins); level channels
// simply register the source.
module int_ctrl_ch #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic clr,
  output logic pend
);
  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev <= 1'b0;
      pend <= 1'b0;
    end else begin
      prev <= src;
      if (EDGE) pend <= (src & ~prev) | (pend & ~clr);
      else      pend <= src;
    end
  end
endmodule

module int_ctrl #(
  parameter int                 NCH       = 4,
  parameter int                 ID_W      = 2,
  parameter logic [NCH-1:0]     EDGE_MASK = {NCH{1'b1}},
  parameter bit                 ROTATE    = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NCH-1:0]  src,
  input  logic            mask_we,
  input  logic [NCH-1:0]  mask_wd,
  input  logic            int_ack,
  input  logic            int_eoi,
  output logic            irq,
  output logic [ID_W-1:0] int_id,
  output logic            in_service,
  output logic [NCH-1:0]  pending,
  output logic [NCH-1:0]  mask
);
  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t          state, state_n;
  logic [ID_W-1:0] ptr;
  logic [NCH-1:0]  eligible;
  logic [NCH-1:0]  clr;
  logic [NCH-1:0]  sh;
  logic [ID_W-1:0] win;
  logic            found;
  logic            grant;
  int              idx;

  assign eligible = pending & mask;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    int_ctrl_ch #(.EDGE(EDGE_MASK[i])) u_ch (
      .clk   (clk),
      .reset (reset),
      .src   (src[i]),
      .clr   (clr[i]),
      .pend  (pending[i])
    );
  end

  // First eligible channel searching upward from ptr with wrap. With fixed
  // priority ptr never leaves 0, so this is plain lowest-index-wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    sh    = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      sh = eligible >> idx;
      if (!found && sh[0]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  // Arbitration happens at the ack edge on the current (old-mask) eligible set.
  assign grant = (state == REQ) && int_ack && found;
  assign clr   = grant ? (NCH'(1) << win) : '0;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (|eligible) state_n = REQ;
      REQ:     if (grant) state_n = SERV;
               else if (~|eligible) state_n = IDLE;
      SERV:    if (int_eoi) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      irq        <= 1'b0;
      in_service <= 1'b0;
      int_id     <= '0;
      ptr        <= '0;
      mask       <= '1;
    end else begin
      state      <= state_n;
      irq        <= (state_n == REQ);
      in_service <= (state_n == SERV);
      if (mask_we) mask <= mask_wd;
      if (grant) begin
        int_id <= win;
        if (ROTATE) ptr <= (win == ID_W'(NCH - 1)) ? '0 : win + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: three instances (fixed/edge, rotating/edge, level on
// channel 0). Grants are expected via a queue popped by a monitor that fires
// whenever in_service rises; state checks are made #1 after clock edges.
module tb_int_ctrl;
  logic       clk = 0;
  logic       reset = 0;
  logic [3:0] src     [3];
  logic       mask_we [3];
  logic [3:0] mask_wd [3];
  logic       ack     [3];
  logic       eoi     [3];
  logic       irq     [3];
  logic [1:0] id      [3];
  logic       svc     [3];
  logic [3:0] pend    [3];
  logic [3:0] msk     [3];
  logic       svc_q   [3];

  typedef struct { int d; logic [1:0] id; } exp_t;
  exp_t q[$];
  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  int_ctrl #(.NCH(4), .ID_W(2), .EDGE_MASK(4'b1111), .ROTATE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .src(src[0]), .mask_we(mask_we[0]), .mask_wd(mask_wd[0]),
    .int_ack(ack[0]), .int_eoi(eoi[0]), .irq(irq[0]), .int_id(id[0]),
    .in_service(svc[0]), .pending(pend[0]), .mask(msk[0]));
  int_ctrl #(.NCH(4), .ID_W(2), .EDGE_MASK(4'b1111), .ROTATE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .src(src[1]), .mask_we(mask_we[1]), .mask_wd(mask_wd[1]),
    .int_ack(ack[1]), .int_eoi(eoi[1]), .irq(irq[1]), .int_id(id[1]),
    .in_service(svc[1]), .pending(pend[1]), .mask(msk[1]));
  int_ctrl #(.NCH(4), .ID_W(2), .EDGE_MASK(4'b1110), .ROTATE(1'b0)) dut2 (
    .clk(clk), .reset(reset), .src(src[2]), .mask_we(mask_we[2]), .mask_wd(mask_wd[2]),
    .int_ack(ack[2]), .int_eoi(eoi[2]), .irq(irq[2]), .int_id(id[2]),
    .in_service(svc[2]), .pending(pend[2]), .mask(msk[2]));

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack(input int d, input logic [1:0] e);
    exp_t x;
    x.d = d; x.id = e;
    q.push_back(x);
    ack[d] = 1; step(); ack[d] = 0;
    chk("ack_id", 32'(id[d]), 32'(e));
    chk("ack_svc", 32'(svc[d]), 1);
    chk("ack_irq", 32'(irq[d]), 0);
  endtask

  task automatic do_eoi(input int d);
    eoi[d] = 1; step(); eoi[d] = 0;
    chk("eoi_svc", 32'(svc[d]), 0);
  endtask

  // Scoreboard monitor: every new grant must match the head of the queue.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (svc[d] === 1'b1 && svc_q[d] !== 1'b1) begin
        if (q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL mon_unexpected: dut%0d granted id %0d with nothing expected", d, id[d]);
        end else begin
          exp_t x;
          x = q.pop_front();
          chk("mon_dut", 32'(d), 32'(x.d));
          chk("mon_id", 32'(id[d]), 32'(x.id));
        end
      end
      svc_q[d] = svc[d];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      src[d] = 0; mask_we[d] = 0; mask_wd[d] = 0; ack[d] = 0; eoi[d] = 0; svc_q[d] = 0;
    end
    #12;
    chk("rst_irq", 32'(irq[0]), 0);
    chk("rst_id", 32'(id[0]), 0);
    chk("rst_svc", 32'(svc[0]), 0);
    chk("rst_pend", 32'(pend[0]), 0);
    chk("rst_mask", 32'(msk[0]), 4'hf);
    reset = 1;
    step();

    // single edge pulse on channel 2
    src[0] = 4'b0100; step(); src[0] = 0;
    chk("t1_pend", 32'(pend[0]), 4'b0100);
    chk("t1_irq_lat", 32'(irq[0]), 0);
    step();
    chk("t1_irq", 32'(irq[0]), 1);
    do_ack(0, 2);
    chk("t1_pend_clr", 32'(pend[0]), 0);
    do_eoi(0);
    chk("t1_irq_eoi", 32'(irq[0]), 0);
    step();
    chk("t1_irq_idle", 32'(irq[0]), 0);

    // two simultaneous edges, fixed priority
    src[0] = 4'b1010; step(); src[0] = 0; step();
    chk("t2_irq", 32'(irq[0]), 1);
    do_ack(0, 1);
    chk("t2_pend", 32'(pend[0]), 4'b1000);
    do_eoi(0);
    step();
    chk("t2_rereq", 32'(irq[0]), 1);
    do_ack(0, 3);
    chk("t2_pend2", 32'(pend[0]), 0);
    do_eoi(0);

    // rotating priority: 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      src[1] = 4'b0011; step(); src[1] = 0; step();
      chk("t3_irq", 32'(irq[1]), 1);
      do_ack(1, (k % 2 == 0) ? 2'd0 : 2'd1);
      do_eoi(1);
    end

    // masking
    mask_we[0] = 1; mask_wd[0] = 4'b1110; step(); mask_we[0] = 0;
    chk("t4_mask", 32'(msk[0]), 4'b1110);
    src[0] = 4'b0001; step(); src[0] = 0;
    chk("t4_pend", 32'(pend[0]), 4'b0001);
    step(); step();
    chk("t4_irq_masked", 32'(irq[0]), 0);
    mask_we[0] = 1; mask_wd[0] = 4'b1111; step(); mask_we[0] = 0;
    step();
    chk("t4_irq_unmask", 32'(irq[0]), 1);
    do_ack(0, 0);
    do_eoi(0);

    // level channel 0
    src[2] = 4'b0001; step(); step();
    chk("t5_irq", 32'(irq[2]), 1);
    do_ack(2, 0);
    chk("t5_pend_kept", 32'(pend[2]), 4'b0001);
    do_eoi(2);
    step();
    chk("t5_rereq", 32'(irq[2]), 1);
    src[2] = 0; step(); step();
    chk("t5_drop_irq", 32'(irq[2]), 0);
    chk("t5_drop_svc", 32'(svc[2]), 0);

    // stray handshakes: ack in IDLE, eoi in REQ
    ack[2] = 1; step(); ack[2] = 0;
    chk("t6_ack_idle_irq", 32'(irq[2]), 0);
    chk("t6_ack_idle_svc", 32'(svc[2]), 0);
    src[2] = 4'b0001; step(); step();
    chk("t6_req_irq", 32'(irq[2]), 1);
    eoi[2] = 1; step(); eoi[2] = 0;
    chk("t6_eoi_req_irq", 32'(irq[2]), 1);
    chk("t6_eoi_req_svc", 32'(svc[2]), 0);
    do_ack(2, 0);

    // reset asserted mid-SERV
    mask_we[0] = 1; mask_wd[0] = 4'b0111; step(); mask_we[0] = 0;
    src[0] = 4'b0110; step(); src[0] = 0; step();
    chk("t7_irq", 32'(irq[0]), 1);
    do_ack(0, 1);
    chk("t7_pend", 32'(pend[0]), 4'b0100);
    @(negedge clk); #1;
    reset = 0;
    #1;
    chk("t7_rst_irq", 32'(irq[0]), 0);
    chk("t7_rst_svc", 32'(svc[0]), 0);
    chk("t7_rst_pend", 32'(pend[0]), 0);
    chk("t7_rst_mask", 32'(msk[0]), 4'hf);
    step();
    chk("sb_empty", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
